aesha_round_sequencer: RTL and testbench

Parametrised control sequencer for the AESHA engine. It captures key, data and mode on a start handshake and drives the shared AES/Keccak datapath through its round schedule. It exposes an explicit round index, a done pulse and an abort path. Round counts, cycles-per-round and operand widths are configurable. It sits between the bus-side register file and the aes/keccak datapath.

---
 rtl/aesha_round_sequencer.sv | 142 ++++++++++++++
 tb/tb_aesha_round_sequencer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aesha_round_sequencer.sv
// Round sequencer for the shared AES/Keccak datapath: latches operands on start,
// then steps the round index through a Keccak pass or a two-pass AES schedule.
module aesha_round_sequencer #(
    parameter int KEY_W         = 128,
    parameter int DATA_W        = 512,
    parameter int AES_ROUNDS    = 10,
    parameter int AES_CPR       = 2,
    parameter int KECCAK_ROUNDS = 24,
    parameter int ROUND_W       = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_aes_or_keccak,
    input  logic               i_enc_or_dec,
    input  logic [KEY_W-1:0]   i_key,
    input  logic [DATA_W-1:0]  i_data,
    output logic               busy,
    output logic               done,
    output logic               aclr,
    output logic               aes_or_keccak,
    output logic               enc_or_dec,
    output logic [KEY_W-1:0]   key,
    output logic [DATA_W-1:0]  data,
    output logic               genkey,
    output logic [ROUND_W-1:0] round
);

    localparam int CNT_W = (AES_CPR > 1) ? $clog2(AES_CPR) : 1;
    localparam logic [ROUND_W-1:0] AES_LAST = ROUND_W'(AES_ROUNDS - 1);
    localparam logic [ROUND_W-1:0] KEC_LAST = ROUND_W'(KECCAK_ROUNDS - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(AES_CPR - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN_KECCAK,
        S_RUN_AES,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cyc, cyc_nxt;
    logic [ROUND_W-1:0] round_nxt;
    logic               genkey_nxt;
    logic               accept;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= S_IDLE;
            cyc           <= '0;
            round         <= '0;
            genkey        <= 1'b1;
            aes_or_keccak <= 1'b0;
            enc_or_dec    <= 1'b0;
            key           <= '0;
            data          <= '0;
        end else begin
            state  <= state_nxt;
            cyc    <= cyc_nxt;
            round  <= round_nxt;
            genkey <= genkey_nxt;
            if (accept) begin
                aes_or_keccak <= i_aes_or_keccak;
                enc_or_dec    <= i_enc_or_dec;
                key           <= i_key;
                data          <= i_data;
            end
        end
    end

    // Every path into IDLE re-initialises round/genkey so the IDLE cycle already shows them.
    always_comb begin
        state_nxt  = state;
        cyc_nxt    = cyc;
        round_nxt  = round;
        genkey_nxt = genkey;
        accept     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        aclr       = 1'b1;
        unique case (state)
            S_IDLE: begin
                busy       = 1'b0;
                aclr       = 1'b0;
                cyc_nxt    = '0;
                round_nxt  = '0;
                genkey_nxt = 1'b1;
                if (i_start) begin
                    accept    = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                aclr = 1'b0;
                if (i_abort) state_nxt = S_IDLE;
                else         state_nxt = aes_or_keccak ? S_RUN_AES : S_RUN_KECCAK;
            end
            S_RUN_KECCAK: begin
                if (i_abort) begin
                    state_nxt  = S_IDLE;
                    round_nxt  = '0;
                    genkey_nxt = 1'b1;
                end else if (round == KEC_LAST) begin
                    state_nxt = S_DONE;
                end else begin
                    round_nxt = round + ROUND_W'(1);
                end
            end
            S_RUN_AES: begin
                if (i_abort) begin
                    state_nxt  = S_IDLE;
                    cyc_nxt    = '0;
                    round_nxt  = '0;
                    genkey_nxt = 1'b1;
                end else if (cyc == CNT_LAST) begin
                    cyc_nxt = '0;
                    if (round != AES_LAST) begin
                        round_nxt = round + ROUND_W'(1);
                    end else if (genkey) begin
                        round_nxt  = '0;
                        genkey_nxt = 1'b0;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end else begin
                    cyc_nxt = cyc + CNT_W'(1);
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_nxt  = S_IDLE;
                cyc_nxt    = '0;
                round_nxt  = '0;
                genkey_nxt = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_aesha_round_sequencer.sv
// Self-checking bench for aesha_round_sequencer: default and overridden instances
// compared cycle by cycle against a schedule model derived from round/cycle arithmetic.
module tb_aesha_round_sequencer;

    localparam int KW = 128;
    localparam int DW = 512;
    localparam logic [8:0] IDLE_V = 9'b0_0_0_1_00000;

    logic          clk = 1'b0;
    logic          i_reset, i_start, i_abort, i_aes_or_keccak, i_enc_or_dec;
    logic [KW-1:0] i_key;
    logic [DW-1:0] i_data;

    logic          busy0, done0, aclr0, mode0, enc0, genkey0;
    logic [KW-1:0] key0;
    logic [DW-1:0] data0;
    logic [4:0]    round0;
    logic          busy1, done1, aclr1, mode1, enc1, genkey1;
    logic [KW-1:0] key1;
    logic [DW-1:0] data1;
    logic [4:0]    round1;
    logic [8:0]    obs0, obs1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [KW-1:0] exp_key;
    logic [DW-1:0] exp_data;
    logic          exp_enc, exp_mode;

    assign obs0 = {busy0, done0, aclr0, genkey0, round0};
    assign obs1 = {busy1, done1, aclr1, genkey1, round1};

    always #5 clk = ~clk;

    aesha_round_sequencer dut0 (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
        .i_aes_or_keccak(i_aes_or_keccak), .i_enc_or_dec(i_enc_or_dec),
        .i_key(i_key), .i_data(i_data),
        .busy(busy0), .done(done0), .aclr(aclr0), .aes_or_keccak(mode0),
        .enc_or_dec(enc0), .key(key0), .data(data0), .genkey(genkey0), .round(round0)
    );

    aesha_round_sequencer #(
        .AES_ROUNDS(14), .AES_CPR(1), .KECCAK_ROUNDS(12)
    ) dut1 (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
        .i_aes_or_keccak(i_aes_or_keccak), .i_enc_or_dec(i_enc_or_dec),
        .i_key(i_key), .i_data(i_data),
        .busy(busy1), .done(done1), .aclr(aclr1), .aes_or_keccak(mode1),
        .enc_or_dec(enc1), .key(key1), .data(data1), .genkey(genkey1), .round(round1)
    );

    // Expected {busy,done,aclr,genkey,round} t cycles after the start-sampling edge.
    function automatic logic [8:0] model(input bit aes, input int t, input int r,
                                         input int c, input int k);
        int len, idx;
        logic [4:0] rd;
        len = aes ? 2 * r * c + 2 : k + 2;
        if (t < 1 || t > len) return IDLE_V;
        if (t == 1) return 9'b1_0_0_1_00000;
        if (t == len) begin
            rd = aes ? 5'(r - 1) : 5'(k - 1);
            return {3'b111, ~aes, rd};
        end
        idx = t - 2;
        if (aes) begin
            rd = 5'((idx % (r * c)) / c);
            return {3'b101, (idx < r * c), rd};
        end
        rd = 5'(idx);
        return {3'b101, 1'b1, rd};
    endfunction

    function automatic int latency(input bit aes, input int r, input int c, input int k);
        return aes ? 2 * r * c + 2 : k + 2;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops;
        for (int w = 0; w < KW / 32; w++) i_key[w*32 +: 32] = $urandom();
        for (int w = 0; w < DW / 32; w++) i_data[w*32 +: 32] = $urandom();
        i_enc_or_dec = 1'($urandom_range(0, 1));
    endtask

    task automatic capture_expected;
        exp_key  = i_key;
        exp_data = i_data;
        exp_enc  = i_enc_or_dec;
        exp_mode = i_aes_or_keccak;
    endtask

    task automatic reset_all;
        i_reset = 1'b1;
        i_start = 1'b0;
        i_abort = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        i_start = 1'b1;
        i_aes_or_keccak = 1'b1;
        rand_ops();
        #3;
        for (int n = 0; n < 3; n++) begin
            n_cmp++;
            if (obs0 !== IDLE_V) begin
                n_bad++;
                $display("FAIL reset_status0 n=%0d: got %b want %b", n, obs0, IDLE_V);
            end
            n_cmp++;
            if (obs1 !== IDLE_V) begin
                n_bad++;
                $display("FAIL reset_status1 n=%0d: got %b want %b", n, obs1, IDLE_V);
            end
            n_cmp++;
            if ({mode0, enc0, mode1, enc1} !== 4'b0000 || key0 !== '0 || data0 !== '0
                || key1 !== '0 || data1 !== '0) begin
                n_bad++;
                $display("FAIL reset_latched n=%0d: got mode/enc %b%b key %h want zeros",
                         n, mode0, enc0, key0);
            end
            tick();
        end
        i_start = 1'b0;
        i_abort = 1'b0;
        i_reset = 1'b0;
        tick();
    endtask

    task automatic test_keccak;
        int len;
        logic [8:0] exp;
        reset_all();
        rand_ops();
        i_aes_or_keccak = 1'b0;
        i_start = 1'b1;
        capture_expected();
        len = latency(1'b0, 10, 2, 24);
        for (int t = 1; t <= len + 1; t++) begin
            tick();
            exp = model(1'b0, t, 10, 2, 24);
            n_cmp++;
            if (obs0 !== exp) begin
                n_bad++;
                $display("FAIL keccak_status t=%0d: got %b want %b", t, obs0, exp);
            end
            n_cmp++;
            if (key0 !== exp_key || data0 !== exp_data || enc0 !== exp_enc || mode0 !== 1'b0) begin
                n_bad++;
                $display("FAIL keccak_latched t=%0d: got key %h enc %b mode %b want key %h enc %b mode 0",
                         t, key0, enc0, mode0, exp_key, exp_enc);
            end
            // stray starts and operand changes while busy must be ignored
            i_start = (t <= len) ? 1'($urandom_range(0, 1)) : 1'b0;
            i_aes_or_keccak = 1'($urandom_range(0, 1));
            rand_ops();
        end
    endtask

    task automatic test_aes;
        int len;
        logic [8:0] exp;
        reset_all();
        rand_ops();
        i_key = 128'h000102030405060708090a0b0c0d0e0f;
        i_enc_or_dec = 1'b1;
        i_aes_or_keccak = 1'b1;
        i_start = 1'b1;
        capture_expected();
        len = latency(1'b1, 10, 2, 24);
        for (int t = 1; t <= len + 1; t++) begin
            tick();
            exp = model(1'b1, t, 10, 2, 24);
            n_cmp++;
            if (obs0 !== exp) begin
                n_bad++;
                $display("FAIL aes_status t=%0d: got %b want %b", t, obs0, exp);
            end
            n_cmp++;
            if (key0 !== 128'h000102030405060708090a0b0c0d0e0f || enc0 !== 1'b1 || mode0 !== 1'b1
                || data0 !== exp_data) begin
                n_bad++;
                $display("FAIL aes_latched t=%0d: got key %h enc %b mode %b want key %h enc 1 mode 1",
                         t, key0, enc0, mode0, exp_key);
            end
            i_start = 1'b0;
            rand_ops();
        end
    endtask

    task automatic test_abort;
        logic [8:0] exp;
        int len, ta;
        bit m;
        reset_all();
        // abort in AES pass 2, round 4 (t = 2 + 20 + 8)
        rand_ops();
        i_aes_or_keccak = 1'b1;
        i_start = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            i_start = 1'b0;
        end
        exp = model(1'b1, 30, 10, 2, 24);
        n_cmp++;
        if (obs0 !== exp || exp !== 9'b1_0_1_0_00100) begin
            n_bad++;
            $display("FAIL abort_pre: got %b want %b", obs0, 9'b1_0_1_0_00100);
        end
        i_abort = 1'b1;
        for (int t = 31; t <= 34; t++) begin
            tick();
            i_abort = 1'b0;
            n_cmp++;
            if (obs0 !== IDLE_V) begin
                n_bad++;
                $display("FAIL abort_idle t=%0d: got %b want %b", t, obs0, IDLE_V);
            end
        end
        // random ops with a random abort point; ta == len aborts during DONE (no effect)
        for (int n = 0; n < 8; n++) begin
            m = 1'($urandom_range(0, 1));
            len = latency(m, 10, 2, 24);
            ta = (n == 7) ? len : int'($urandom_range(1, len - 1));
            rand_ops();
            i_aes_or_keccak = m;
            i_start = 1'b1;
            i_abort = (n == 0);
            for (int t = 1; t <= ta + 1; t++) begin
                tick();
                exp = (t <= ta) ? model(m, t, 10, 2, 24) : IDLE_V;
                n_cmp++;
                if (obs0 !== exp) begin
                    n_bad++;
                    $display("FAIL abort_rand n=%0d ta=%0d t=%0d: got %b want %b",
                             n, ta, t, obs0, exp);
                end
                i_start = 1'b0;
                i_abort = (t == ta);
            end
        end
    endtask

    task automatic test_async_reset;
        int len;
        logic [8:0] exp;
        reset_all();
        rand_ops();
        i_aes_or_keccak = 1'b0;
        i_start = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            tick();
            i_start = 1'b0;
        end
        n_cmp++;
        if (obs0 !== 9'b1_0_1_1_00111) begin
            n_bad++;
            $display("FAIL areset_pre: got %b want %b", obs0, 9'b1_0_1_1_00111);
        end
        #2;
        i_reset = 1'b1;
        #1;
        n_cmp++;
        if (obs0 !== IDLE_V || key0 !== '0 || data0 !== '0 || mode0 !== 1'b0 || enc0 !== 1'b0) begin
            n_bad++;
            $display("FAIL areset_no_edge: got %b key %h want %b key 0", obs0, key0, IDLE_V);
        end
        tick();
        i_reset = 1'b0;
        rand_ops();
        i_aes_or_keccak = 1'b1;
        i_start = 1'b1;
        len = latency(1'b1, 10, 2, 24);
        for (int t = 1; t <= len + 1; t++) begin
            tick();
            i_start = 1'b0;
            exp = model(1'b1, t, 10, 2, 24);
            n_cmp++;
            if (obs0 !== exp) begin
                n_bad++;
                $display("FAIL areset_aes t=%0d: got %b want %b", t, obs0, exp);
            end
        end
    endtask

    task automatic test_override;
        int len;
        logic [8:0] exp;
        bit m;
        for (int n = 0; n < 2; n++) begin
            reset_all();
            m = (n == 0);
            rand_ops();
            i_aes_or_keccak = m;
            i_start = 1'b1;
            capture_expected();
            len = latency(m, 14, 1, 12);
            for (int t = 1; t <= len + 1; t++) begin
                tick();
                i_start = 1'b0;
                exp = model(m, t, 14, 1, 12);
                n_cmp++;
                if (obs1 !== exp) begin
                    n_bad++;
                    $display("FAIL override_status mode=%0d t=%0d: got %b want %b", m, t, obs1, exp);
                end
                n_cmp++;
                if (key1 !== exp_key || mode1 !== m || enc1 !== exp_enc) begin
                    n_bad++;
                    $display("FAIL override_latched t=%0d: got key %h mode %b want key %h mode %b",
                             t, key1, mode1, exp_key, m);
                end
                rand_ops();
            end
        end
    endtask

    task automatic test_back_to_back;
        int len;
        logic [8:0] exp;
        bit m;
        reset_all();
        m = 1'b0;
        rand_ops();
        i_aes_or_keccak = m;
        i_start = 1'b1;
        capture_expected();
        for (int op = 0; op < 6; op++) begin
            len = latency(m, 10, 2, 24);
            for (int t = 1; t <= len + 1; t++) begin
                tick();
                exp = model(m, t, 10, 2, 24);
                n_cmp++;
                if (obs0 !== exp) begin
                    n_bad++;
                    $display("FAIL b2b_status op=%0d t=%0d: got %b want %b", op, t, obs0, exp);
                end
                n_cmp++;
                if (mode0 !== m || key0 !== exp_key) begin
                    n_bad++;
                    $display("FAIL b2b_latched op=%0d t=%0d: got mode %b key %h want mode %b key %h",
                             op, t, mode0, key0, m, exp_key);
                end
                rand_ops();
                if (t <= len) begin
                    i_aes_or_keccak = 1'($urandom_range(0, 1));
                end else begin
                    m = ~m;
                    i_aes_or_keccak = m;
                    i_start = (op < 5);
                    capture_expected();
                end
            end
        end
        tick();
        n_cmp++;
        if (obs0 !== IDLE_V) begin
            n_bad++;
            $display("FAIL b2b_final_idle: got %b want %b", obs0, IDLE_V);
        end
    endtask

    initial begin
        i_reset = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;
        i_aes_or_keccak = 1'b0;
        i_enc_or_dec = 1'b0;
        i_key = '0;
        i_data = '0;
        tick();
        test_reset();
        test_keccak();
        test_aes();
        test_abort();
        test_async_reset();
        test_override();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
